// File: rtl/mem_fifo_ctrl_if.sv
// Push/pop side of the mem_fifo_ctrl FIFO controller.
// The slave modport is the controller; the master modport is the datapath that pushes and pops.
interface mem_fifo_ctrl_if #(
  parameter int AW = 9,
  parameter int DW = 20
);
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          rd_en;
  logic [DW-1:0] rd_data;
  logic          rd_dval;
  logic          full;
  logic          empty;
  logic [AW:0]   level;
  logic          ovf;
  logic          unf;
  logic          almost_full;
  logic          almost_empty;

  modport slave (
    input  wr_en, wr_data, rd_en,
    output rd_data, rd_dval, full, empty, level, ovf, unf, almost_full, almost_empty
  );

  modport master (
    output wr_en, wr_data, rd_en,
    input  rd_data, rd_dval, full, empty, level, ovf, unf, almost_full, almost_empty
  );
endinterface

// File: rtl/mem_fifo_ctrl.sv
// FIFO controller driving the write and read ports of an external 2**AW x DW two-port memory.
// Optional almost_full/almost_empty watermarks are built when MEM_FIFO_WATERMARK_EN is defined.
module mem_fifo_ctrl #(
  parameter int AW     = 9,
  parameter int DW     = 20,
  parameter int AF_LVL = 448,
  parameter int AE_LVL = 64
) (
  input  logic          clk,
  input  logic          rst,
  mem_fifo_ctrl_if.slave fifo,
  output logic [AW-1:0] mem_wa,
  output logic          mem_write,
  output logic [DW-1:0] mem_d,
  output logic [AW-1:0] mem_ra,
  input  logic [DW-1:0] mem_q
);

  localparam logic [AW:0] DEPTH_LVL = (AW+1)'(1 << AW);

  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]   level_reg, level_next;
  logic          full_reg, empty_reg;
  logic          rd_dval_reg, ovf_reg, unf_reg;
  logic          push_ok, pop_ok;

  // Accept decisions use only registered flags, so no input reaches a flag combinationally.
  assign push_ok = fifo.wr_en & ~full_reg & ~rst;
  assign pop_ok  = fifo.rd_en & ~empty_reg & ~rst;

  always_comb begin
    level_next = level_reg;
    case ({push_ok, pop_ok})
      2'b10:   level_next = level_reg + 1'b1;
      2'b01:   level_next = level_reg - 1'b1;
      default: level_next = level_reg;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      level_reg   <= '0;
      full_reg    <= 1'b0;
      empty_reg   <= 1'b1;
      rd_dval_reg <= 1'b0;
      ovf_reg     <= 1'b0;
      unf_reg     <= 1'b0;
    end else begin
      // Pointers wrap through natural AW-bit overflow.
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      level_reg   <= level_next;
      full_reg    <= (level_next == DEPTH_LVL);
      empty_reg   <= (level_next == '0);
      rd_dval_reg <= pop_ok;
      if (fifo.wr_en && full_reg)  ovf_reg <= 1'b1;
      if (fifo.rd_en && empty_reg) unf_reg <= 1'b1;
    end
  end

`ifdef MEM_FIFO_WATERMARK_EN
  localparam logic [AW:0] AF_TH = (AW+1)'(AF_LVL);
  localparam logic [AW:0] AE_TH = (AW+1)'(AE_LVL);

  logic almost_full_reg, almost_empty_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      almost_full_reg  <= 1'b0;
      almost_empty_reg <= 1'b1;
    end else begin
      almost_full_reg  <= (level_next >= AF_TH);
      almost_empty_reg <= (level_next <= AE_TH);
    end
  end

  assign fifo.almost_full  = almost_full_reg;
  assign fifo.almost_empty = almost_empty_reg;
`else
  assign fifo.almost_full  = 1'b0;
  assign fifo.almost_empty = 1'b0;
`endif

  assign mem_wa    = wr_ptr_reg;
  assign mem_write = push_ok;
  assign mem_d     = fifo.wr_data;
  assign mem_ra    = rd_ptr_reg;

  assign fifo.rd_data = mem_q;
  assign fifo.rd_dval = rd_dval_reg;
  assign fifo.full    = full_reg;
  assign fifo.empty   = empty_reg;
  assign fifo.level   = level_reg;
  assign fifo.ovf     = ovf_reg;
  assign fifo.unf     = unf_reg;

endmodule

// File: tb/tb_mem_fifo_ctrl.sv
// Randomized bench for mem_fifo_ctrl with a two-port memory model and a queue-based FIFO reference.
// Watermark expectations follow MEM_FIFO_WATERMARK_EN, matching the build of the design.
module tb_mem_fifo_ctrl;
  localparam int AW    = 9;
  localparam int DW    = 20;
  localparam int DEPTH = 1 << AW;
  localparam int AF    = 448;
  localparam int AE    = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] mem_wa, mem_ra;
  logic          mem_write;
  logic [DW-1:0] mem_d;
  logic [DW-1:0] mem_q;

  mem_fifo_ctrl_if #(.AW(AW), .DW(DW)) bus ();

  mem_fifo_ctrl #(.AW(AW), .DW(DW), .AF_LVL(AF), .AE_LVL(AE)) dut (
    .clk       (clk),
    .rst       (rst),
    .fifo      (bus),
    .mem_wa    (mem_wa),
    .mem_write (mem_write),
    .mem_d     (mem_d),
    .mem_ra    (mem_ra),
    .mem_q     (mem_q)
  );

  always #5 clk = ~clk;

  // Two-port memory: synchronous write, registered read of ra.
  logic [DW-1:0] mem_arr [DEPTH];
  always @(posedge clk) begin
    if (mem_write) mem_arr[mem_wa] <= mem_d;
    mem_q <= mem_arr[mem_ra];
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: contents in order, accepted-op counts, sticky flags.
  logic [DW-1:0] mq[$];
  int  wcnt, rcnt;
  bit  m_ovf, m_unf;

  task automatic check_state(input bit exp_dval, input logic [DW-1:0] exp_d);
    int lvl;
    lvl = mq.size();
    chk("level", 32'(bus.level), lvl);
    chk("full", 32'(bus.full), 32'(lvl == DEPTH));
    chk("empty", 32'(bus.empty), 32'(lvl == 0));
    chk("ovf", 32'(bus.ovf), 32'(m_ovf));
    chk("unf", 32'(bus.unf), 32'(m_unf));
    chk("rd_dval", 32'(bus.rd_dval), 32'(exp_dval));
    if (exp_dval) chk("rd_data", 32'(bus.rd_data), 32'(exp_d));
`ifdef MEM_FIFO_WATERMARK_EN
    chk("almost_full", 32'(bus.almost_full), 32'(lvl >= AF));
    chk("almost_empty", 32'(bus.almost_empty), 32'(lvl <= AE));
`else
    chk("almost_full", 32'(bus.almost_full), 0);
    chk("almost_empty", 32'(bus.almost_empty), 0);
`endif
  endtask

  // Entered at posedge+1; leaves at the next posedge+1.
  task automatic step(input bit wr, input logic [DW-1:0] wd, input bit rd);
    bit push_ok, pop_ok;
    logic [DW-1:0] exp_d;
    bus.wr_en   = wr;
    bus.wr_data = wd;
    bus.rd_en   = rd;
    push_ok = wr && (mq.size() < DEPTH);
    pop_ok  = rd && (mq.size() > 0);
    #3;
    chk("mem_write", 32'(mem_write), 32'(push_ok));
    chk("mem_wa", 32'(mem_wa), wcnt % DEPTH);
    chk("mem_ra", 32'(mem_ra), rcnt % DEPTH);
    if (push_ok) chk("mem_d", 32'(mem_d), 32'(wd));
    @(posedge clk);
    #1;
    exp_d = '0;
    if (pop_ok) begin
      exp_d = mq.pop_front();
      rcnt++;
    end
    if (push_ok) begin
      mq.push_back(wd);
      wcnt++;
    end
    if (wr && !push_ok) m_ovf = 1'b1;
    if (rd && !pop_ok)  m_unf = 1'b1;
    check_state(pop_ok, exp_d);
  endtask

  task automatic reset_dut();
    bus.wr_en   = 1'b1;
    bus.rd_en   = 1'b1;
    bus.wr_data = '0;
    rst = 1'b1;
    #2;
    mq.delete();
    wcnt = 0;
    rcnt = 0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
    chk("rst_mem_write", 32'(mem_write), 0);
    chk("rst_level", 32'(bus.level), 0);
    chk("rst_empty", 32'(bus.empty), 1);
    chk("rst_full", 32'(bus.full), 0);
    chk("rst_ovf", 32'(bus.ovf), 0);
    chk("rst_unf", 32'(bus.unf), 0);
    chk("rst_rd_dval", 32'(bus.rd_dval), 0);
`ifdef MEM_FIFO_WATERMARK_EN
    chk("rst_almost_empty", 32'(bus.almost_empty), 1);
`else
    chk("rst_almost_empty", 32'(bus.almost_empty), 0);
`endif
    chk("rst_almost_full", 32'(bus.almost_full), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    #1;
    check_state(1'b0, '0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.wr_en   = 1'b0;
    bus.rd_en   = 1'b0;
    bus.wr_data = '0;
    @(posedge clk);
    #1;
    reset_dut();

    // Fill to full with i+512.
    for (int i = 0; i < DEPTH; i++) step(1'b1, DW'(i + 512), 1'b0);
    // Overflow: lone push, then push+pop while full (push dropped, pop taken).
    step(1'b1, 20'hABCDE, 1'b0);
    step(1'b1, 20'hABCDE, 1'b1);
    // Drain everything, ending in underflow with a same-cycle push.
    for (int i = 0; i < DEPTH - 1; i++) step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);
    step(1'b1, 20'h12345, 1'b1);
    step(1'b0, '0, 1'b1);

    // Simultaneous push+pop at level 5.
    for (int i = 0; i < 5; i++) step(1'b1, DW'($urandom), 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, DW'($urandom), 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1);

    // Wrap: prefill 3, then 1000 cycles of push+pop.
    reset_dut();
    for (int i = 0; i < 3; i++) step(1'b1, DW'($urandom), 1'b0);
    for (int i = 0; i < 1000; i++) step(1'b1, DW'($urandom), 1'b1);

    // Reset mid-fill at level 100 with a read in flight.
    reset_dut();
    for (int i = 0; i < 100; i++) step(1'b1, DW'($urandom), 1'b0);
    step(1'b1, DW'($urandom), 1'b1);
    reset_dut();

    // Watermark crossings: fill past AF, drain below AE.
    for (int i = 0; i < AF + 4; i++) step(1'b1, DW'($urandom), 1'b0);
    for (int i = 0; i < AF - AE + 8; i++) step(1'b0, '0, 1'b1);

    // Random traffic with shifting bias to visit empty and full.
    reset_dut();
    for (int i = 0; i < 1500; i++) begin
      int bias;
      bias = (i / 300) % 2 == 0 ? 80 : 20;
      step($urandom_range(99) < bias, DW'($urandom), $urandom_range(99) >= bias);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
